wallace_mac_accumulator: RTL

//   Sequential multiply-accumulate stage that consumes the 8-bit product of the 4x4 wallace_tree multiplier.

---
 rtl/wallace_mac_accumulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wallace_mac_accumulator.sv
// ============================================================================
// Module   : wallace_mac_accumulator (+ wallace_tree)
// Purpose  : Multiply-accumulate stage summing COUNT 4x4 Wallace-tree products
//            per result, with valid/ready on both the input and output sides.
//            Optional macro SATURATE_EN clamps the accumulator instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wallace_tree (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] prod
);
    logic [7:0] w_r0, w_r1, w_r2, w_r3;
    logic [7:0] w_s1, w_c1, w_s2, w_c2;
    logic [6:0] w_m1, w_m2;

    assign w_r0 = {4'b0000, a & {4{b[0]}}};
    assign w_r1 = {3'b000,  a & {4{b[1]}}, 1'b0};
    assign w_r2 = {2'b00,   a & {4{b[2]}}, 2'b00};
    assign w_r3 = {1'b0,    a & {4{b[3]}}, 3'b000};

    // Two carry-save layers reduce four rows to two; bit 8 carries are dropped
    // because the full product never exceeds 225.
    assign w_s1 = w_r0 ^ w_r1 ^ w_r2;
    assign w_m1 = (w_r0[6:0] & w_r1[6:0]) | (w_r0[6:0] & w_r2[6:0]) | (w_r1[6:0] & w_r2[6:0]);
    assign w_c1 = {w_m1, 1'b0};

    assign w_s2 = w_s1 ^ w_c1 ^ w_r3;
    assign w_m2 = (w_s1[6:0] & w_c1[6:0]) | (w_s1[6:0] & w_r3[6:0]) | (w_c1[6:0] & w_r3[6:0]);
    assign w_c2 = {w_m2, 1'b0};

    assign prod = w_s2 + w_c2;
endmodule

module wallace_mac_accumulator #(
    parameter int ACC_W = 16,
    parameter int COUNT = 8,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(COUNT - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_op_a;
    logic [3:0]       r_op_b;
    logic             r_pipe_v;
    logic             r_ovf;

    logic [7:0]       w_prod;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_accept;

    wallace_tree u_mult (
        .a    (r_op_a),
        .b    (r_op_b),
        .prod (w_prod)
    );

    assign w_accept = in_valid && (r_state == ST_ACC);
    assign w_sum    = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, w_prod};
    assign w_carry  = w_sum[ACC_W];

`ifdef SATURATE_EN
    // Once clamped, any further nonzero product carries out again and re-clamps.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ACC;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_pipe_v <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_state  <= ST_ACC;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pipe_v <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_pipe_v <= w_accept;
            if (w_accept) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
            end
            if (r_pipe_v) begin
                r_acc <= w_acc_next;
                if (w_carry) begin
                    r_ovf <= 1'b1;
                end
            end
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: r_state <= ST_HOLD;
                ST_HOLD: begin
                    // The pipeline is empty in HOLD, so clearing here cannot race an add.
                    if (out_ready) begin
                        r_state <= ST_ACC;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_HOLD);
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
endmodule

`default_nettype wire
